histo_equalizer: RTL and testbench

- Consumer-side reader of the cumulative-histogram read port. On each histogram-complete pulse it sweeps all 256 cumulative bins through the address/data read interface and builds an 8-bit equalization LUT: LUT[g] = floor(cum[g]*255/cum[255]).
- It then remaps the live gray pixel stream through that LUT.
- It sits downstream of the histogram/threshold block, alongside the threshold path.

---
 rtl/histo_equalizer.sv | 181 ++++++++++++++++++
 tb/tb_histo_equalizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_equalizer.sv
`timescale 1ns/1ps
// Builds an 8-bit equalization LUT from the cumulative histogram (double-banked)
// and remaps the live gray pixel stream through the active bank with 2-cycle latency.
module histo_equalizer #(
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned CUM_W  = 20
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    output logic [7:0]       oReadGray,
    input  logic [CUM_W-1:0] iCumHisto,
    input  logic             iFvalid,
    input  logic [7:0]       iGray,
    input  logic             iGrayValid,
    output logic [7:0]       oEqGray,
    output logic             oEqValid,
    output logic             oBusy,
    output logic             oLutReady
);

    localparam int unsigned NW = CUM_W + 8;
    localparam int unsigned WW = $clog2(RD_LAT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_TOTAL, S_FETCH, S_DIV, S_WR, S_PEND
    } state_t;

    state_t            state;
    logic              start_d;
    logic [7:0]        bin;
    logic [WW-1:0]     wait_cnt;
    logic [CUM_W-1:0]  total;
    logic [NW-1:0]     rem;
    logic [NW-1:0]     div_sub;
    logic [NW-1:0]     n_val;
    logic [NW-1:0]     c_ext;
    logic [7:0]        quot;
    logic [2:0]        div_i;
    logic              sel;
    logic              lut_ready;
    logic              busy;
    logic [7:0]        read_gray;

    logic [7:0]        lut [512];
    logic              lut_we;
    logic [8:0]        lut_waddr;

    logic [7:0]        gray_s1;
    logic              valid_s1;
    logic              sel_s1;
    logic              ready_s1;
    logic [7:0]        eq_gray;
    logic              eq_valid;

    assign c_ext   = NW'(iCumHisto);
    assign n_val   = (c_ext << 8) - c_ext;
    assign div_sub = NW'(total) << div_i;

    assign lut_we    = (state == S_WR);
    assign lut_waddr = {~sel, bin};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= S_IDLE;
            start_d   <= 1'b0;
            bin       <= '0;
            wait_cnt  <= '0;
            total     <= '0;
            rem       <= '0;
            quot      <= '0;
            div_i     <= '0;
            sel       <= 1'b0;
            lut_ready <= 1'b0;
            busy      <= 1'b0;
            read_gray <= '0;
        end else begin
            start_d <= iStart;
            case (state)
                S_IDLE: begin
                    if (iStart && !start_d) begin
                        busy      <= 1'b1;
                        read_gray <= '1;
                        wait_cnt  <= '0;
                        state     <= S_TOTAL;
                    end
                end
                S_TOTAL: begin
                    if (wait_cnt == WAIT_LAST) begin
                        total     <= iCumHisto;
                        bin       <= '0;
                        read_gray <= '0;
                        wait_cnt  <= '0;
                        state     <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        // An empty histogram has no meaningful scale: write identity.
                        if (total == '0) begin
                            quot  <= bin;
                            state <= S_WR;
                        end else begin
                            rem   <= n_val;
                            quot  <= '0;
                            div_i <= 3'd7;
                            state <= S_DIV;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (rem >= div_sub) begin
                        rem         <= rem - div_sub;
                        quot[div_i] <= 1'b1;
                    end
                    if (div_i == 3'd0) begin
                        state <= S_WR;
                    end else begin
                        div_i <= div_i - 3'd1;
                    end
                end
                S_WR: begin
                    if (bin == 8'hFF) begin
                        state <= S_PEND;
                    end else begin
                        bin       <= bin + 8'd1;
                        read_gray <= bin + 8'd1;
                        state     <= S_FETCH;
                    end
                end
                S_PEND: begin
                    // Swap only between frames so no frame sees two LUTs.
                    if (!iFvalid) begin
                        sel       <= ~sel;
                        lut_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (lut_we) begin
            lut[lut_waddr] <= quot;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            gray_s1  <= '0;
            valid_s1 <= 1'b0;
            sel_s1   <= 1'b0;
            ready_s1 <= 1'b0;
            eq_gray  <= '0;
            eq_valid <= 1'b0;
        end else begin
            gray_s1  <= iGray;
            valid_s1 <= iGrayValid;
            sel_s1   <= sel;
            ready_s1 <= lut_ready;
            eq_gray  <= ready_s1 ? lut[{sel_s1, gray_s1}] : gray_s1;
            eq_valid <= valid_s1;
        end
    end

    assign oReadGray = read_gray;
    assign oEqGray   = eq_gray;
    assign oEqValid  = eq_valid;
    assign oBusy     = busy;
    assign oLutReady = lut_ready;

endmodule

// File: tb/tb_histo_equalizer.sv
`timescale 1ns/1ps
// Scoreboard bench for histo_equalizer: a 3-register cumulative-histogram read port
// model feeds the DUT; expected pixels are queued at drive time and popped on oEqValid.
module tb_histo_equalizer;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iStart = 1'b0;
    logic        iFvalid = 1'b0;
    logic [7:0]  iGray = '0;
    logic        iGrayValid = 1'b0;
    logic [19:0] iCumHisto;
    logic [7:0]  oReadGray;
    logic [7:0]  oEqGray;
    logic        oEqValid;
    logic        oBusy;
    logic        oLutReady;

    histo_equalizer #(.RD_LAT(3), .CUM_W(20)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .oReadGray(oReadGray),
        .iCumHisto(iCumHisto), .iFvalid(iFvalid), .iGray(iGray),
        .iGrayValid(iGrayValid), .oEqGray(oEqGray), .oEqValid(oEqValid),
        .oBusy(oBusy), .oLutReady(oLutReady)
    );

    always #5 iClk = ~iClk;

    logic [19:0] cum_mem [256];
    logic [7:0]  a1;
    logic [19:0] a2, cum_q;
    always @(posedge iClk) begin
        a1    <= oReadGray;
        a2    <= cum_mem[a1];
        cum_q <= a2;
    end
    assign iCumHisto = cum_q;

    int          total_cnt = 0;
    int          bad_cnt = 0;
    int unsigned cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  val;
        int unsigned cyc;
    } sb_t;
    sb_t         sb[$];
    logic [7:0]  act_lut [256];
    bit          ready_m = 1'b0;
    logic [7:0]  rd_log[$];
    bit          rec_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge iClk) begin
        sb_t e;
        if (iRst_n && oEqValid) begin
            if (sb.size() == 0) begin
                check("extra_valid", 32'(oEqValid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("eq_gray", 32'(oEqGray), 32'(e.val));
                check("eq_lat", 32'(cyc), 32'(e.cyc + 2));
            end
        end
        if (rec_en && oBusy && (rd_log.size() == 0 || rd_log[$] != oReadGray))
            rd_log.push_back(oReadGray);
    end

    function automatic void build_model();
        longint t;
        t = longint'(cum_mem[255]);
        for (int g = 0; g < 256; g++)
            act_lut[g] = (t == 0) ? 8'(g) : 8'((longint'(cum_mem[g]) * 255) / t);
        ready_m = 1'b1;
    endfunction

    task automatic drive(input logic [7:0] g, input logic v);
        sb_t e;
        @(posedge iClk);
        #1;
        iGray      = g;
        iGrayValid = v;
        if (v) begin
            e.val = ready_m ? act_lut[g] : g;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic stream_all();
        for (int g = 0; g < 256; g++) drive(8'(g), 1'b1);
        drive(8'd0, 1'b0);
        repeat (4) @(posedge iClk);
    endtask

    task automatic pulse_start();
        @(posedge iClk);
        #1 iStart = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        check("busy_rise", 32'(oBusy), 32'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (oBusy && n < maxc) begin
            @(negedge iClk);
            n++;
        end
        check("build_done", 32'(oBusy), 32'd0);
        check("lut_ready", 32'(oLutReady), 32'd1);
        #1 iStart = 1'b0;
    endtask

    task automatic fill_random();
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 256; i++) begin
            acc += $urandom_range(0, 300);
            cum_mem[i] = 20'(acc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad_entries;
        logic [7:0] exp_rd;

        for (int i = 0; i < 256; i++) cum_mem[i] = 20'(i + 1);
        repeat (3) @(posedge iClk);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ready", 32'(oLutReady), 32'd0);
        check("rst_valid", 32'(oEqValid), 32'd0);
        check("rst_rdgray", 32'(oReadGray), 32'd0);
        check("rst_eqgray", 32'(oEqGray), 32'd0);
        @(negedge iClk) iRst_n = 1'b1;

        // bypass before any build
        iFvalid = 1'b1;
        for (int g = 0; g < 16; g++) drive(8'(g * 13 + 7), 1'b1);
        drive(8'd0, 1'b0);
        repeat (4) @(posedge iClk);
        iFvalid = 1'b0;

        // uniform histogram -> identity
        pulse_start();
        wait_idle(4000);
        build_model();
        iFvalid = 1'b1;
        stream_all();
        iFvalid = 1'b0;

        // single-bin histogram, build finishing while frame is valid
        for (int i = 0; i < 256; i++) cum_mem[i] = (i < 100) ? 20'd0 : 20'd1000;
        iFvalid = 1'b1;
        pulse_start();
        repeat (3400) @(negedge iClk);
        check("pend_busy", 32'(oBusy), 32'd1);
        check("pend_ready", 32'(oLutReady), 32'd1);
        check("pend_rdgray", 32'(oReadGray), 32'd255);
        stream_all();
        iFvalid = 1'b0;
        wait_idle(20);
        build_model();
        iFvalid = 1'b1;
        stream_all();
        iFvalid = 1'b0;

        // all-zero histogram -> identity without divide
        for (int i = 0; i < 256; i++) cum_mem[i] = 20'd0;
        pulse_start();
        wait_idle(4000);
        build_model();
        iFvalid = 1'b1;
        stream_all();
        iFvalid = 1'b0;

        // second start edge while busy is ignored
        fill_random();
        rd_log.delete();
        rec_en = 1'b1;
        pulse_start();
        repeat (200) @(posedge iClk);
        #1 iStart = 1'b0;
        @(posedge iClk);
        #1 iStart = 1'b1;
        wait_idle(4000);
        rec_en = 1'b0;
        check("rd_len", 32'(rd_log.size()), 32'd257);
        bad_entries = 0;
        for (int k = 0; k < rd_log.size() && k < 257; k++) begin
            exp_rd = (k == 0) ? 8'd255 : 8'(k - 1);
            if (rd_log[k] !== exp_rd) bad_entries++;
        end
        check("rd_seq", 32'(bad_entries), 32'd0);
        repeat (30) @(negedge iClk);
        check("no_rebuild", 32'(oBusy), 32'd0);
        build_model();
        iFvalid = 1'b1;
        for (int k = 0; k < 64; k++) drive(8'($urandom_range(0, 255)), 1'b1);
        drive(8'd0, 1'b0);
        repeat (4) @(posedge iClk);
        iFvalid = 1'b0;

        // reset in the middle of a build
        fill_random();
        pulse_start();
        n = 0;
        while (oReadGray != 8'd128 && n < 3000) begin
            @(negedge iClk);
            n++;
        end
        check("reach_bin128", 32'(oReadGray), 32'd128);
        #1 iRst_n = 1'b0;
        iStart = 1'b0;
        #1;
        check("arst_busy", 32'(oBusy), 32'd0);
        check("arst_ready", 32'(oLutReady), 32'd0);
        check("arst_valid", 32'(oEqValid), 32'd0);
        check("arst_rdgray", 32'(oReadGray), 32'd0);
        ready_m = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk) iRst_n = 1'b1;
        iFvalid = 1'b1;
        stream_all();
        iFvalid = 1'b0;
        check("post_rst_idle", 32'(oBusy), 32'd0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
